// File: rtl/int2float_pipe.sv
// rtl/int2float_pipe.sv - three-stage integer to binary32 converter (FCVT.S.W/WU/L/LU)
module int2float_pipe #(
    parameter int INT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] int_in,
    input  logic             is_unsigned,
    input  logic [2:0]       rm,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [4:0]       fflags,
    output logic [TAG_W-1:0] tag_out
);
    localparam int LZ_W = $clog2(INT_W) + 1;

    logic             w_en;
    logic             w_sign;
    logic [INT_W-1:0] w_mag;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [INT_W-1:0] r_s1_mag;
    logic [2:0]       r_s1_rm;
    logic [TAG_W-1:0] r_s1_tag;

    logic [LZ_W-1:0]  w_lz;
    logic [INT_W-1:0] w_norm;
    logic [7:0]       w_exp;

    logic             r_s2_valid;
    logic             r_s2_sign;
    logic [INT_W-1:0] r_s2_norm;
    logic [7:0]       r_s2_exp;
    logic             r_s2_zero;
    logic [2:0]       r_s2_rm;
    logic [TAG_W-1:0] r_s2_tag;

    logic [23:0]      w_mant;
    logic             w_g;
    logic             w_s;
    logic             w_nx;
    logic             w_inc;
    logic [24:0]      w_sum;
    logic [7:0]       w_exp_r;
    logic [31:0]      w_res;
    logic [4:0]       w_ff;

    logic             r_out_valid;
    logic [31:0]      r_result;
    logic [4:0]       r_fflags;
    logic [TAG_W-1:0] r_tag_out;

    // The whole pipe freezes on backpressure, so bubbles are never squeezed out.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    assign w_sign = !is_unsigned && int_in[INT_W-1];
    assign w_mag  = w_sign ? (INT_W'(0) - int_in) : int_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_rm    <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_sign;
            r_s1_mag   <= w_mag;
            r_s1_rm    <= rm;
            r_s1_tag   <= tag_in;
        end
    end

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (r_s1_mag[i]) w_lz = LZ_W'(INT_W - 1 - i);
        end
    end

    assign w_norm = r_s1_mag << w_lz;
    assign w_exp  = 8'(127 + INT_W - 1 - int'(w_lz));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_norm  <= '0;
            r_s2_exp   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_rm    <= '0;
            r_s2_tag   <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_norm  <= w_norm;
            r_s2_exp   <= w_exp;
            r_s2_zero  <= (r_s1_mag == '0);
            r_s2_rm    <= r_s1_rm;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign w_mant = r_s2_norm[INT_W-1 -: 24];
    assign w_g    = r_s2_norm[INT_W-25];
    assign w_s    = |r_s2_norm[INT_W-26:0];
    assign w_nx   = w_g | w_s;

    always_comb begin
        w_inc = 1'b0;
        case (r_s2_rm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = w_nx & r_s2_sign;
            3'b011:  w_inc = w_nx & ~r_s2_sign;
            3'b100:  w_inc = w_g;
            default: w_inc = w_g & (w_s | w_mant[0]);
        endcase
    end

    // sum[24:23] is 2'b01 normally and 2'b10 on mantissa carry-out, so it doubles as the exponent bump.
    assign w_sum   = {1'b0, w_mant} + 25'(w_inc);
    assign w_exp_r = r_s2_exp - 8'd1 + 8'(w_sum[24:23]);
    assign w_res   = r_s2_zero ? 32'h0 : {r_s2_sign, w_exp_r, w_sum[22:0]};
    assign w_ff    = r_s2_zero ? 5'h0 : {4'b0, w_nx};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_fflags    <= '0;
            r_tag_out   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            r_result    <= w_res;
            r_fflags    <= w_ff;
            r_tag_out   <= r_s2_tag;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign fflags    = r_fflags;
    assign tag_out   = r_tag_out;
endmodule

// File: tb/tb_int2float_pipe.sv
// tb/tb_int2float_pipe.sv - scoreboard bench running 32- and 64-bit converters in lockstep
module tb_int2float_pipe;
    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, is_unsigned, out_ready;
    logic [2:0]  rm;
    logic [4:0]  tag_in;
    logic [31:0] int_in32;
    logic [63:0] int_in64;
    logic        in_ready32, in_ready64, out_valid32, out_valid64;
    logic [31:0] result32, result64;
    logic [4:0]  fflags32, fflags64, tag_out32, tag_out64;

    int n_vec = 0;
    int n_err = 0;
    int nc    = 0;

    typedef struct {
        logic [32:0] e32;
        logic [32:0] e64;
        logic [4:0]  tag;
        int          t;
        bit          lat;
    } exp_t;
    exp_t        q[$];
    logic [32:0] cur_e32, cur_e64;
    logic [4:0]  tag_ctr = 5'd0;
    bit          lat_chk = 1'b1;

    always #5 clk = ~clk;

    int2float_pipe #(.INT_W(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .int_in(int_in32), .is_unsigned(is_unsigned), .rm(rm), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready), .result(result32), .fflags(fflags32),
        .tag_out(tag_out32)
    );

    int2float_pipe #(.INT_W(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .int_in(int_in64), .is_unsigned(is_unsigned), .rm(rm), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready), .result(result64), .fflags(fflags64),
        .tag_out(tag_out64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Independent reference: shift-right-with-remainder rounding on a 64-bit magnitude.
    function automatic logic [32:0] ref_cvt(input logic [63:0] v, input int w, input logic uns,
                                            input logic [2:0] r);
        logic [63:0] x, mag, rem, half, m;
        logic        s, inc, nx;
        logic [7:0]  e;
        int          p, sh;
        x   = (w == 32) ? {32'b0, v[31:0]} : v;
        s   = !uns && x[w-1];
        mag = s ? ((~x + 64'd1) & ((w == 32) ? 64'h0000_0000_FFFF_FFFF : '1)) : x;
        if (mag == 64'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        e   = 8'(127 + p);
        nx  = 1'b0;
        inc = 1'b0;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            nx   = (rem != 64'd0);
            case (r)
                3'd1:    inc = 1'b0;
                3'd2:    inc = nx && s;
                3'd3:    inc = nx && !s;
                3'd4:    inc = (rem >= half);
                default: inc = (rem > half) || (rem == half && m[0]);
            endcase
        end
        m = m + 64'(inc);
        if (m[24]) begin
            m = 64'h80_0000;
            e = e + 8'd1;
        end
        return {nx, s, e, m[22:0]};
    endfunction

    always @(negedge clk) begin
        exp_t it;
        nc++;
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid32, 1'b0);
                end else begin
                    it = q.pop_front();
                    check("res32", result32, it.e32[31:0]);
                    check("ff32", fflags32, {4'b0, it.e32[32]});
                    check("tag32", tag_out32, it.tag);
                    check("ov64", out_valid64, 1'b1);
                    check("res64", result64, it.e64[31:0]);
                    check("ff64", fflags64, {4'b0, it.e64[32]});
                    check("tag64", tag_out64, it.tag);
                    if (it.lat) check("latency", nc - it.t, 3);
                end
            end
            if (in_valid && in_ready32) q.push_back('{cur_e32, cur_e64, tag_in, nc, lat_chk});
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic drive(input logic [63:0] v, input logic uns, input logic [2:0] r,
                         input logic [32:0] e32, input logic [32:0] e64);
        bit acc;
        int_in32    = v[31:0];
        int_in64    = v;
        is_unsigned = uns;
        rm          = r;
        tag_in      = tag_ctr;
        cur_e32     = e32;
        cur_e64     = e64;
        in_valid    = 1'b1;
        acc         = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready32 && reset_n && !flush;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 0, 1);
        tag_ctr  = tag_ctr + 5'd1;
        in_valid = 1'b0;
    endtask

    task automatic dd(input logic [63:0] v, input logic uns, input logic [2:0] r, input logic [32:0] e);
        drive(v, uns, r, e, e);
    endtask

    task automatic drive_rand();
        logic [63:0] v;
        logic        u;
        logic [2:0]  r;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) v = v >> $urandom_range(8, 60);
        u = 1'($urandom_range(0, 1));
        r = 3'($urandom_range(0, 7));
        drive(v, u, r, ref_cvt(v, 32, u, r), ref_cvt(v, 64, u, r));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ov"}, out_valid32, 1'b0);
        check({name, "_res"}, result32, 32'h0);
        check({name, "_ff"}, fflags32, 5'h0);
        check({name, "_tag"}, tag_out32, 5'h0);
        check({name, "_res64"}, result64, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        bit          seen;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        is_unsigned = 1'b0; rm = 3'd0; tag_in = 5'd0; int_in32 = '0; int_in64 = '0;
        cur_e32 = '0; cur_e64 = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_in_ready", in_ready32, 1'b1);
        @(posedge clk);
        #1;

        // Directed values, issued back to back.
        dd(64'h0000_0000_7FFF_FFFF, 1'b0, 3'd0, {1'b1, 32'h4F00_0000});
        dd(64'h0000_0000_7FFF_FFFF, 1'b0, 3'd1, {1'b1, 32'h4EFF_FFFF});
        dd(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, {1'b0, 32'hBF80_0000});
        dd(64'hFFFF_FFFF_8000_0000, 1'b0, 3'd0, {1'b0, 32'hCF00_0000});
        dd(64'h0000_0000_0100_0001, 1'b0, 3'd0, {1'b1, 32'h4B80_0000});
        dd(64'h0000_0000_0100_0003, 1'b0, 3'd0, {1'b1, 32'h4B80_0002});
        dd(64'h0000_0000_0100_0001, 1'b0, 3'd4, {1'b1, 32'h4B80_0001});
        dd(64'h0000_0000_0100_0001, 1'b0, 3'd3, {1'b1, 32'h4B80_0001});
        dd(64'h0000_0000_0100_0001, 1'b0, 3'd2, {1'b1, 32'h4B80_0000});
        dd(64'h0000_0000_0100_0001, 1'b0, 3'd5, {1'b1, 32'h4B80_0000});
        dd(64'hFFFF_FFFF_FEFF_FFFF, 1'b0, 3'd2, {1'b1, 32'hCB80_0001});
        dd(64'hFFFF_FFFF_FEFF_FFFF, 1'b0, 3'd3, {1'b1, 32'hCB80_0000});
        dd(64'h0000_0000_FFFF_FFFF, 1'b1, 3'd0, {1'b1, 32'h4F80_0000});
        for (int r = 0; r < 8; r++) dd(64'h0, 1'(r), 3'(r), 33'h0);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, {1'b1, 32'h4F80_0000}, {1'b1, 32'h5F80_0000});
        drive(64'h8000_0000_0000_0000, 1'b0, 3'd0, 33'h0, {1'b0, 32'hDF00_0000});
        drain();

        // Streaming: the per-item latency check makes the results consecutive.
        for (int i = 0; i < 8; i++) drive_rand();
        drain();

        // Backpressure: freeze the pipe for 4 cycles after the first result.
        lat_chk = 1'b0;
        fork
            for (int i = 0; i < 5; i++) drive_rand();
            begin
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = out_valid32;
                end
                check("bp_first_out", seen, 1'b1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held_res = result32;
                held_tag = tag_out32;
                check("bp_out_valid", out_valid32, 1'b1);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    check("bp_in_ready", in_ready32, 1'b0);
                    check("bp_res_hold", result32, held_res);
                    check("bp_tag_hold", tag_out32, held_tag);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Flush with three ops in flight; the op presented alongside flush is dropped.
        for (int i = 0; i < 3; i++) drive_rand();
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_ov", out_valid32, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        drive_rand();
        drain();

        // Reset (with a simultaneous flush) in the middle of traffic.
        for (int i = 0; i < 3; i++) drive_rand();
        reset_n = 1'b0;
        flush   = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (5) @(posedge clk);
        #1;
        drive_rand();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
